// File: rtl/bus_responder.sv
// Memory/peripheral end of the 65C02 bus: RAM, vector bytes and a timer I/O page; DB is registered one cycle after AB.
// Defining BUS_TRACE_EN adds last-opcode-fetch trace registers at I/O offsets 8-10.
module bus_responder #(
    parameter int unsigned RAM_AW    = 12,
    parameter logic [15:0] IO_BASE   = 16'hFE00,
    parameter logic [15:0] RESET_VEC = 16'hF000,
    parameter logic [15:0] IRQ_VEC   = 16'hF100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] AB,
    input  logic [7:0]  DO,
    input  logic        WE,
    input  logic        sync,
    output logic [7:0]  DB,
    output logic        irq
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [7:0]  mem [2**RAM_AW];
    logic [15:0] reload_q, reload_d, count_q, count_d;
    logic        ie_q, ie_d, auto_q, auto_d, exp_q, exp_d, irq_q;
    logic [7:0]  shadow_q, shadow_d, scratch_q, scratch_d, db_q, rd_dat;
    logic        io_hit, vec_hit, ram_hit, io_wr, exp_evt, en_d;
    logic [3:0]  io_off;

    assign io_off  = AB[3:0];
    assign io_hit  = (AB[15:4] == IO_BASE[15:4]);
    assign vec_hit = !io_hit && (AB >= 16'hFFFA);
    assign ram_hit = !io_hit && !vec_hit && ((AB >> RAM_AW) == 16'h0000);
    assign io_wr   = WE && io_hit;
    assign exp_evt = (state_q == RUN) && (count_q == 16'h0000);

`ifdef BUS_TRACE_EN
    logic [15:0] trace_pc_q;
    logic [7:0]  trace_op_q;
    logic        sync_q;

    // The fetched opcode appears on DB the cycle after sync, so latch it then.
    always_ff @(posedge clk) begin
        if (reset) begin
            trace_pc_q <= 16'h0000;
            trace_op_q <= 8'h00;
            sync_q     <= 1'b0;
        end else begin
            if (sync)
                trace_pc_q <= AB;
            if (sync_q)
                trace_op_q <= db_q;
            sync_q <= sync;
        end
    end
`else
    logic unused_sync;
    assign unused_sync = sync;
`endif

    always_comb begin
        rd_dat = 8'hFF;
        if (io_hit) begin
            unique case (io_off)
                4'd0:    rd_dat = reload_q[7:0];
                4'd1:    rd_dat = reload_q[15:8];
                4'd2:    rd_dat = {5'b00000, auto_q, ie_q, state_q == RUN};
                4'd3:    rd_dat = {7'b0000000, exp_q};
                4'd4:    rd_dat = count_q[7:0];
                4'd5:    rd_dat = shadow_q;
                4'd6:    rd_dat = scratch_q;
`ifdef BUS_TRACE_EN
                4'd8:    rd_dat = trace_pc_q[7:0];
                4'd9:    rd_dat = trace_pc_q[15:8];
                4'd10:   rd_dat = trace_op_q;
`endif
                default: rd_dat = 8'h00;
            endcase
        end else if (vec_hit) begin
            unique case (AB[2:0])
                3'd4:    rd_dat = RESET_VEC[7:0];
                3'd5:    rd_dat = RESET_VEC[15:8];
                3'd6:    rd_dat = IRQ_VEC[7:0];
                3'd7:    rd_dat = IRQ_VEC[15:8];
                default: rd_dat = 8'h00;
            endcase
        end else if (ram_hit) begin
            rd_dat = mem[AB[RAM_AW-1:0]];
        end
    end

    // EN is not stored separately: it is exactly "state is RUN".
    always_comb begin
        reload_d  = reload_q;
        ie_d      = ie_q;
        auto_d    = auto_q;
        shadow_d  = shadow_q;
        scratch_d = scratch_q;
        count_d   = count_q;
        exp_d     = exp_q;
        en_d      = (state_q == RUN);

        if (exp_evt && !auto_q)
            en_d = 1'b0;
        if (io_wr) begin
            unique case (io_off)
                4'd0:    reload_d[7:0]  = DO;
                4'd1:    reload_d[15:8] = DO;
                4'd2: begin
                    en_d   = DO[0];
                    ie_d   = DO[1];
                    auto_d = DO[2];
                end
                4'd6:    scratch_d = DO;
                default: ;
            endcase
        end
        if (io_hit && io_off == 4'd4)
            shadow_d = count_q[15:8];

        // Expiry set takes priority over a simultaneous write-1-clear.
        if (io_wr && io_off == 4'd3 && DO[0])
            exp_d = 1'b0;
        if (exp_evt)
            exp_d = 1'b1;

        if (state_q == IDLE) begin
            if (en_d)
                count_d = reload_q;
        end else if (en_d) begin
            count_d = (count_q == 16'h0000) ? reload_q : count_q - 16'd1;
        end

        state_d = en_d ? RUN : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            reload_q  <= 16'h0000;
            count_q   <= 16'h0000;
            ie_q      <= 1'b0;
            auto_q    <= 1'b0;
            exp_q     <= 1'b0;
            irq_q     <= 1'b0;
            shadow_q  <= 8'h00;
            scratch_q <= 8'h00;
            db_q      <= 8'h00;
        end else begin
            state_q   <= state_d;
            reload_q  <= reload_d;
            count_q   <= count_d;
            ie_q      <= ie_d;
            auto_q    <= auto_d;
            exp_q     <= exp_d;
            irq_q     <= exp_q & ie_q;
            shadow_q  <= shadow_d;
            scratch_q <= scratch_d;
            db_q      <= rd_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (WE && ram_hit)
            mem[AB[RAM_AW-1:0]] <= DO;
    end

    assign DB  = db_q;
    assign irq = irq_q;

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: directed bus scenarios plus random traffic against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_bus_responder;

    localparam logic [15:0] IO = 16'hFE00;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] AB;
    logic [7:0]  DO;
    logic        WE, sync;
    logic [7:0]  DB;
    logic        irq;

    always #5 clk = ~clk;

    bus_responder dut (
        .clk(clk), .reset(reset), .AB(AB), .DO(DO), .WE(WE),
        .sync(sync), .DB(DB), .irq(irq)
    );

    int n_vec = 0;
    int n_err = 0;

    bit [7:0]  m_mem   [4096];
    bit        m_known [4096];
    bit [15:0] m_reload, m_count, m_tpc;
    bit        m_run, m_ie, m_auto, m_exp, m_irq, m_psync, m_db_known;
    bit [7:0]  m_shadow, m_scratch, m_db, m_top;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_reload = 0; m_count = 0; m_run = 0; m_ie = 0; m_auto = 0; m_exp = 0;
        m_irq = 0; m_shadow = 0; m_scratch = 0; m_db = 0; m_db_known = 1;
        m_tpc = 0; m_top = 0; m_psync = 0;
    endtask

    // One bus cycle: what the responder answers, and how the register file evolves.
    task automatic model_step(input bit [15:0] a, input bit [7:0] d, input bit w, input bit s);
        bit [7:0] rv;
        bit       kn, io, wr, expire, run_n, ie_n, auto_n;
        bit [3:0] off;
        rv = 8'hFF; kn = 1;
        io = (a[15:4] == IO[15:4]);
        off = a[3:0];
        wr = io && w;
        if (io) begin
            case (off)
                0: rv = m_reload[7:0];
                1: rv = m_reload[15:8];
                2: rv = {5'b0, m_auto, m_ie, m_run};
                3: rv = {7'b0, m_exp};
                4: rv = m_count[7:0];
                5: rv = m_shadow;
                6: rv = m_scratch;
`ifdef BUS_TRACE_EN
                8: rv = m_tpc[7:0];
                9: rv = m_tpc[15:8];
                10: rv = m_top;
`endif
                default: rv = 8'h00;
            endcase
        end else if (a >= 16'hFFFA) begin
            case (a)
                16'hFFFD: rv = 8'hF0;
                16'hFFFF: rv = 8'hF1;
                default:  rv = 8'h00;
            endcase
        end else if (a < 16'h1000) begin
            rv = m_mem[a[11:0]];
            kn = m_known[a[11:0]];
        end

        m_irq = m_exp && m_ie;
        if (m_psync) m_top = m_db;
        if (s) m_tpc = a;
        m_psync = s;
        m_db = rv;
        m_db_known = kn;
        if (io && off == 4) m_shadow = m_count[15:8];

        expire = m_run && (m_count == 0);
        run_n = m_run && !(expire && !m_auto);
        ie_n = m_ie; auto_n = m_auto;
        if (wr && off == 2) begin run_n = d[0]; ie_n = d[1]; auto_n = d[2]; end
        if (!m_run && run_n)     m_count = m_reload;
        else if (m_run && run_n) m_count = (m_count == 0) ? m_reload : m_count - 1;
        if (expire)                          m_exp = 1;
        else if (wr && off == 3 && d[0])     m_exp = 0;
        m_run = run_n; m_ie = ie_n; m_auto = auto_n;
        if (wr && off == 0) m_reload[7:0]  = d;
        if (wr && off == 1) m_reload[15:8] = d;
        if (wr && off == 6) m_scratch = d;
        if (w && a < 16'h1000) begin m_mem[a[11:0]] = d; m_known[a[11:0]] = 1; end
    endtask

    task automatic cyc(input logic [15:0] a, input logic [7:0] d, input bit w, input bit s = 0);
        @(negedge clk);
        AB = a; DO = d; WE = w; sync = s;
        model_step(a, d, w, s);
        @(posedge clk); #1;
        if (m_db_known) chk("db", {8'h00, DB}, {8'h00, m_db});
        chk("irq", {15'h0, irq}, {15'h0, m_irq});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; WE = 0; sync = 0;
        @(posedge clk); #1;
        model_reset();
        chk("rst_db", {8'h00, DB}, 16'h0000);
        chk("rst_irq", {15'h0, irq}, 16'h0000);
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        reset = 1; AB = 0; DO = 0; WE = 0; sync = 0;
        for (int i = 0; i < 4096; i++) m_known[i] = 0;
        do_reset();

        cyc(16'hFFFC, 8'h00, 0); chk("vec_fffc", {8'h00, DB}, 16'h0000);
        cyc(16'hFFFD, 8'h00, 0); chk("vec_fffd", {8'h00, DB}, 16'h00F0);
        cyc(16'hFFFE, 8'h00, 0); chk("vec_fffe", {8'h00, DB}, 16'h0000);
        cyc(16'hFFFF, 8'h00, 0); chk("vec_ffff", {8'h00, DB}, 16'h00F1);
        cyc(16'hFFFD, 8'h77, 1);
        cyc(16'hFFFD, 8'h00, 0); chk("vec_wr_ignored", {8'h00, DB}, 16'h00F0);

        cyc(16'h0123, 8'h5A, 1);
        cyc(16'h0123, 8'h00, 0); chk("ram_rd", {8'h00, DB}, 16'h005A);
        cyc(16'h0123, 8'h33, 1); chk("ram_rbw", {8'h00, DB}, 16'h005A);
        cyc(16'h2000, 8'h00, 0); chk("unmapped", {8'h00, DB}, 16'h00FF);

        // One-shot: RELOAD=3, EN|IE.
        cyc(IO + 16'd0, 8'h03, 1);
        cyc(IO + 16'd1, 8'h00, 1);
        cyc(IO + 16'd2, 8'h03, 1);
        for (int i = 1; i <= 5; i++) begin
            cyc(IO + 16'd3, 8'h00, 0);
            chk("oneshot_exp", {8'h00, DB}, (i == 5) ? 16'd1 : 16'd0);
            chk("oneshot_irq", {15'h0, irq}, (i == 5) ? 16'd1 : 16'd0);
        end
        cyc(IO + 16'd2, 8'h00, 0); chk("oneshot_ctrl", {8'h00, DB}, 16'h0002);
        cyc(IO + 16'd4, 8'h00, 0); chk("oneshot_cnt", {8'h00, DB}, 16'h0000);
        cyc(IO + 16'd3, 8'h01, 1);
        cyc(IO + 16'd3, 8'h00, 0); chk("w1c", {8'h00, DB}, 16'h0000);
        chk("w1c_irq", {15'h0, irq}, 16'h0000);

        // Auto-reload of 1: expiry every other cycle; clear collides with expiry.
        cyc(IO + 16'd0, 8'h01, 1);
        cyc(IO + 16'd2, 8'h07, 1);
        repeat (3) cyc(IO + 16'd3, 8'h00, 0);
        cyc(IO + 16'd3, 8'h01, 1);
        cyc(IO + 16'd3, 8'h00, 0); chk("race_exp", {8'h00, DB}, 16'h0001);
        chk("race_irq", {15'h0, irq}, 16'h0001);
        cyc(IO + 16'd2, 8'h00, 1);
        cyc(IO + 16'd3, 8'h01, 1);
        cyc(IO + 16'd3, 8'h00, 0); chk("stop_exp", {8'h00, DB}, 16'h0000);

        // Coherent 16-bit COUNT read through SHADOW.
        cyc(IO + 16'd0, 8'hF0, 1);
        cyc(IO + 16'd1, 8'h12, 1);
        cyc(IO + 16'd2, 8'h01, 1);
        cyc(IO + 16'd4, 8'h00, 0); chk("cnt_lo", {8'h00, DB}, 16'h00F0);
        cyc(IO + 16'd5, 8'h00, 0); chk("cnt_hi", {8'h00, DB}, 16'h0012);
        cyc(IO + 16'd2, 8'h00, 1);
        cyc(IO + 16'd0, 8'h02, 1);
        cyc(IO + 16'd1, 8'h13, 1);
        cyc(IO + 16'd2, 8'h01, 1);
        repeat (2) cyc(IO + 16'd6, 8'h00, 0);
        cyc(IO + 16'd4, 8'h00, 0); chk("cnt_lo_b", {8'h00, DB}, 16'h0000);
        cyc(IO + 16'd5, 8'h00, 0); chk("cnt_hi_b", {8'h00, DB}, 16'h0013);
        cyc(IO + 16'd2, 8'h00, 1);

        // Opcode fetch trace.
        cyc(16'h0200, 8'hA9, 1);
        cyc(16'h0200, 8'h00, 0, 1);
`ifdef BUS_TRACE_EN
        cyc(IO + 16'd8,  8'h00, 0); chk("trace_pc_lo", {8'h00, DB}, 16'h0000);
        cyc(IO + 16'd9,  8'h00, 0); chk("trace_pc_hi", {8'h00, DB}, 16'h0002);
        cyc(IO + 16'd10, 8'h00, 0); chk("trace_op",    {8'h00, DB}, 16'h00A9);
`else
        cyc(IO + 16'd8,  8'h00, 0); chk("trace_pc_lo", {8'h00, DB}, 16'h0000);
        cyc(IO + 16'd9,  8'h00, 0); chk("trace_pc_hi", {8'h00, DB}, 16'h0000);
        cyc(IO + 16'd10, 8'h00, 0); chk("trace_op",    {8'h00, DB}, 16'h0000);
`endif

        for (int i = 0; i < 16; i++) cyc(16'h0100 + 16'(i), 8'($urandom), 1);
        for (int i = 0; i < 3000; i++) begin
            int          sel;
            logic [15:0] a;
            logic [7:0]  d;
            bit          w, s;
            sel = $urandom_range(0, 9);
            d = 8'($urandom);
            w = ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 4) == 0);
            if (sel < 5)      a = IO | 16'($urandom_range(0, 15));
            else if (sel < 7) a = 16'h0100 + 16'($urandom_range(0, 15));
            else if (sel < 8) a = 16'hFFFA + 16'($urandom_range(0, 5));
            else              a = 16'($urandom_range(16'h1000, 16'hFDFF));
            if (a == IO + 16'd1) d = 8'($urandom_range(0, 1));
            cyc(a, d, w, s);
        end

        // Reset in the middle of a count.
        cyc(IO + 16'd0, 8'h00, 1);
        cyc(IO + 16'd1, 8'h01, 1);
        cyc(IO + 16'd2, 8'h07, 1);
        repeat (4) cyc(IO + 16'd6, 8'h00, 0);
        do_reset();
        cyc(IO + 16'd2, 8'h00, 0); chk("rst_ctrl", {8'h00, DB}, 16'h0000);
        cyc(IO + 16'd4, 8'h00, 0); chk("rst_cnt", {8'h00, DB}, 16'h0000);
        cyc(IO + 16'd1, 8'h00, 0); chk("rst_reload", {8'h00, DB}, 16'h0000);
        cyc(16'h0123, 8'h00, 0); chk("ram_kept", {8'h00, DB}, 16'h0033);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
